// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by shot_responder and the game controller.
//   msg_t      reply code carried on msg_out (NONE/MISS/HIT/DEFEAT)
//   state_t    responder FSM state encoding (ST_IDLE..ST_DEFEAT)
//   addr_row / addr_col  extract the row/col fields of an 8-bit cell address
package game_pkg;

  typedef enum logic [1:0] {
    MSG_NONE   = 2'b00,
    MSG_MISS   = 2'b01,
    MSG_HIT    = 2'b10,
    MSG_DEFEAT = 2'b11
  } msg_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOOKUP = 2'd1;
  localparam state_t ST_REPLY  = 2'd2;
  localparam state_t ST_DEFEAT = 2'd3;

  // Address layout: [7:4] row, [3:0] col
  localparam int unsigned ADDR_ROW_MSB = 7;
  localparam int unsigned ADDR_ROW_LSB = 4;
  localparam int unsigned ADDR_COL_MSB = 3;
  localparam int unsigned ADDR_COL_LSB = 0;

  function automatic logic [3:0] addr_row(input logic [7:0] addr);
    return addr[ADDR_ROW_MSB:ADDR_ROW_LSB];
  endfunction

  function automatic logic [3:0] addr_col(input logic [7:0] addr);
    return addr[ADDR_COL_MSB:ADDR_COL_LSB];
  endfunction

endpackage

// File: rtl/board_map.sv
// board_map: ship and shot bitmaps for the own board.
//   clk, rst           clock, asynchronous active-high reset (clears both maps)
//   clear              synchronous clear of both maps (wins over the set strobes)
//   set_ship/ship_idx  mark a cell as ship
//   set_shot/shot_idx  mark a cell as already shot
//   rd_idx             combinational read index -> rd_ship, rd_shot
module board_map #(
  parameter int unsigned CELLS = 100,
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             set_ship,
  input  logic [IDX_W-1:0] ship_idx,
  input  logic             set_shot,
  input  logic [IDX_W-1:0] shot_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_ship,
  output logic             rd_shot
);

  logic [CELLS-1:0] r_ship;
  logic [CELLS-1:0] r_shot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ship <= '0;
      r_shot <= '0;
    end else if (clear) begin
      r_ship <= '0;
      r_shot <= '0;
    end else begin
      if (set_ship) r_ship[ship_idx] <= 1'b1;
      if (set_shot) r_shot[shot_idx] <= 1'b1;
    end
  end

  assign rd_ship = r_ship[rd_idx];
  assign rd_shot = r_shot[rd_idx];

endmodule

// File: rtl/shot_responder.sv
// shot_responder: answers opponent shots against the own board.
//   clk, rst     clock, asynchronous active-high reset
//   new_game     synchronous clear of maps/counter, back to IDLE (highest priority)
//   place_en, place_addr   mark a ship cell (IDLE only, dropped if a shot is accepted)
//   shot_valid, shot_addr, shot_ready   shot handshake
//   msg_out, msg_valid, msg_ack         reply handshake (MISS/HIT/DEFEAT)
//   hits_taken   distinct own ship cells hit (saturates at SHIP_CELLS)
//   defeated     all ship cells hit; responder parked until rst/new_game
module shot_responder
  import game_pkg::*;
#(
  parameter int unsigned BOARD_DIM  = 10,
  parameter int unsigned SHIP_CELLS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       place_en,
  input  logic [7:0] place_addr,
  input  logic       shot_valid,
  input  logic [7:0] shot_addr,
  output logic       shot_ready,
  output logic [1:0] msg_out,
  output logic       msg_valid,
  input  logic       msg_ack,
  output logic [4:0] hits_taken,
  output logic       defeated
);

  localparam int unsigned CELLS = BOARD_DIM * BOARD_DIM;
  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  state_t     r_state;
  logic [7:0] r_addr;
  msg_t       r_msg;
  logic [4:0] r_hits;

  logic             w_shot_in_range;
  logic             w_place_in_range;
  logic [IDX_W-1:0] w_shot_idx;
  logic [IDX_W-1:0] w_place_idx;
  logic             w_rd_ship;
  logic             w_rd_shot;
  logic             w_hit;
  logic [4:0]       w_hits_next;
  msg_t             w_result;
  logic             w_set_ship;
  logic             w_set_shot;

  // Range check done one bit wider so BOARD_DIM=16 still compares correctly.
  assign w_shot_in_range  = ({1'b0, addr_row(r_addr)} < 5'(BOARD_DIM)) &&
                            ({1'b0, addr_col(r_addr)} < 5'(BOARD_DIM));
  assign w_place_in_range = ({1'b0, addr_row(place_addr)} < 5'(BOARD_DIM)) &&
                            ({1'b0, addr_col(place_addr)} < 5'(BOARD_DIM));

  // Out-of-range addresses map to index 0; every use is gated by the range flag.
  assign w_shot_idx  = w_shot_in_range
                     ? IDX_W'(addr_row(r_addr)) * IDX_W'(BOARD_DIM) + IDX_W'(addr_col(r_addr))
                     : '0;
  assign w_place_idx = w_place_in_range
                     ? IDX_W'(addr_row(place_addr)) * IDX_W'(BOARD_DIM) + IDX_W'(addr_col(place_addr))
                     : '0;

  assign w_set_ship = (r_state == ST_IDLE) && place_en && !shot_valid && w_place_in_range;
  assign w_set_shot = (r_state == ST_LOOKUP) && w_shot_in_range;

  board_map #(
    .CELLS (CELLS),
    .IDX_W (IDX_W)
  ) u_map (
    .clk      (clk),
    .rst      (rst),
    .clear    (new_game),
    .set_ship (w_set_ship),
    .ship_idx (w_place_idx),
    .set_shot (w_set_shot),
    .shot_idx (w_shot_idx),
    .rd_idx   (w_shot_idx),
    .rd_ship  (w_rd_ship),
    .rd_shot  (w_rd_shot)
  );

  assign w_hit       = w_shot_in_range && w_rd_ship && !w_rd_shot;
  assign w_hits_next = (r_hits < 5'(SHIP_CELLS)) ? r_hits + 5'd1 : r_hits;

  always_comb begin
    w_result = MSG_MISS;
    if (w_hit) begin
      w_result = (w_hits_next == 5'(SHIP_CELLS)) ? MSG_DEFEAT : MSG_HIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_msg   <= MSG_NONE;
      r_hits  <= '0;
    end else if (new_game) begin
      r_state <= ST_IDLE;
      r_msg   <= MSG_NONE;
      r_hits  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (shot_valid) begin
            r_addr  <= shot_addr;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_msg   <= w_result;
          if (w_hit) r_hits <= w_hits_next;
          r_state <= ST_REPLY;
        end
        ST_REPLY: begin
          if (msg_ack) r_state <= (r_msg == MSG_DEFEAT) ? ST_DEFEAT : ST_IDLE;
        end
        ST_DEFEAT: r_state <= ST_DEFEAT;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign shot_ready = (r_state == ST_IDLE);
  assign msg_valid  = (r_state == ST_REPLY);
  assign msg_out    = msg_valid ? r_msg : MSG_NONE;
  assign hits_taken = r_hits;
  assign defeated   = (r_state == ST_DEFEAT);

endmodule

// File: tb/tb_shot_responder.sv
// Testbench for shot_responder: directed checks followed by randomized shots and
// placements, compared against a board model kept as 2-D arrays of ship/shot flags.
module tb_shot_responder;

  localparam int DIM = 10;
  localparam int SC  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_game;
  logic       place_en;
  logic [7:0] place_addr;
  logic       shot_valid;
  logic [7:0] shot_addr;
  logic       shot_ready;
  logic [1:0] msg_out;
  logic       msg_valid;
  logic       msg_ack;
  logic [4:0] hits_taken;
  logic       defeated;

  shot_responder #(
    .BOARD_DIM  (DIM),
    .SHIP_CELLS (SC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .new_game   (new_game),
    .place_en   (place_en),
    .place_addr (place_addr),
    .shot_valid (shot_valid),
    .shot_addr  (shot_addr),
    .shot_ready (shot_ready),
    .msg_out    (msg_out),
    .msg_valid  (msg_valid),
    .msg_ack    (msg_ack),
    .hits_taken (hits_taken),
    .defeated   (defeated)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference board model
  bit          m_ship [16][16];
  bit          m_shot [16][16];
  int          m_hits;
  bit          m_defeated;
  logic [7:0]  placed_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        m_ship[r][c] = 1'b0;
        m_shot[r][c] = 1'b0;
      end
    m_hits     = 0;
    m_defeated = 1'b0;
    placed_q.delete();
  endtask

  function automatic bit in_range(input logic [7:0] a);
    return (int'(a[7:4]) < DIM) && (int'(a[3:0]) < DIM);
  endfunction

  // Expected reply: 1 MISS, 2 HIT, 3 DEFEAT
  task automatic model_shot(input logic [7:0] a, output int code);
    int r, c;
    r = int'(a[7:4]);
    c = int'(a[3:0]);
    code = 1;
    if (in_range(a)) begin
      if (m_ship[r][c] && !m_shot[r][c]) begin
        m_hits++;
        code = (m_hits == SC) ? 3 : 2;
      end
      m_shot[r][c] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic place(input logic [7:0] a);
    place_en   = 1'b1;
    place_addr = a;
    step();
    place_en   = 1'b0;
    if (in_range(a)) begin
      m_ship[int'(a[7:4])][int'(a[3:0])] = 1'b1;
      placed_q.push_back(a);
    end
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    model_clear();
    chk("newgame/ready", shot_ready, 1);
    chk("newgame/hits", hits_taken, 0);
    chk("newgame/defeated", defeated, 0);
  endtask

  // Full shot transaction; with noise set, place_en is driven (to paddr) on the
  // accepting edge and through LOOKUP/REPLY, where it must have no effect.
  task automatic shoot(input string tag, input logic [7:0] a, input int hold,
                       input bit noise, input logic [7:0] paddr);
    int exp;
    chk({tag, "/ready"}, shot_ready, 1);
    model_shot(a, exp);
    shot_valid = 1'b1;
    shot_addr  = a;
    place_en   = noise;
    place_addr = paddr;
    step();
    shot_valid = 1'b0;
    shot_addr  = 8'($urandom);
    chk({tag, "/lookup_valid"}, msg_valid, 0);
    chk({tag, "/lookup_ready"}, shot_ready, 0);
    step();
    chk({tag, "/valid"}, msg_valid, 1);
    chk({tag, "/code"}, msg_out, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "/hold_valid"}, msg_valid, 1);
      chk({tag, "/hold_code"}, msg_out, exp);
      chk({tag, "/hold_ready"}, shot_ready, 0);
    end
    msg_ack = 1'b1;
    step();
    msg_ack  = 1'b0;
    place_en = 1'b0;
    if (exp == 3) m_defeated = 1'b1;
    chk({tag, "/hits"}, hits_taken, m_hits);
    chk({tag, "/defeated"}, defeated, m_defeated);
    chk({tag, "/ready_after"}, shot_ready, !m_defeated);
    chk({tag, "/valid_after"}, msg_valid, 0);
    chk({tag, "/code_after"}, msg_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp;
    rst        = 1'b1;
    new_game   = 1'b0;
    place_en   = 1'b0;
    place_addr = '0;
    shot_valid = 1'b0;
    shot_addr  = '0;
    msg_ack    = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst/valid", msg_valid, 0);
    chk("rst/code", msg_out, 0);
    chk("rst/hits", hits_taken, 0);
    chk("rst/defeated", defeated, 0);
    rst = 1'b0;
    #1;
    chk("rst/ready_first", shot_ready, 1);
    step();

    // Hit, repeat hit, water, out of range
    place(8'h23);
    shoot("hit23", 8'h23, 0, 1'b0, 8'h00);
    shoot("rehit23", 8'h23, 0, 1'b0, 8'h00);
    shoot("water55", 8'h55, 0, 1'b0, 8'h00);
    // Long hold with placement attempts during LOOKUP/REPLY (must be ignored)
    shoot("oor_A0", 8'hA0, 5, 1'b1, 8'h66);
    shoot("oor_0A", 8'h0A, 1, 1'b0, 8'h00);
    shoot("noplace66", 8'h66, 0, 1'b0, 8'h00);
    // Out-of-range placement is ignored
    place(8'hB5);
    shoot("oor_B5", 8'hB5, 0, 1'b0, 8'h00);

    // Defeat with SHIP_CELLS=2
    do_new_game();
    place(8'h00);
    place(8'h01);
    place(8'h01);
    shoot("def00", 8'h00, 0, 1'b0, 8'h00);
    shoot("def01", 8'h01, 2, 1'b0, 8'h00);
    shot_valid = 1'b1;
    shot_addr  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("defeat/valid", msg_valid, 0);
      chk("defeat/ready", shot_ready, 0);
      chk("defeat/defeated", defeated, 1);
      chk("defeat/hits", hits_taken, SC);
    end
    shot_valid = 1'b0;
    do_new_game();

    // Same-edge place + shot: shot wins, placement dropped
    shoot("shotwins", 8'h77, 0, 1'b1, 8'h44);
    shoot("dropped44", 8'h44, 0, 1'b0, 8'h00);

    // new_game during REPLY discards the reply
    place(8'h12);
    model_shot(8'h12, exp);
    shot_valid = 1'b1;
    shot_addr  = 8'h12;
    step();
    shot_valid = 1'b0;
    step();
    chk("ngreply/valid", msg_valid, 1);
    chk("ngreply/code", msg_out, exp);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    model_clear();
    chk("ngreply/valid_drop", msg_valid, 0);
    chk("ngreply/code_drop", msg_out, 0);
    chk("ngreply/hits", hits_taken, 0);
    chk("ngreply/ready", shot_ready, 1);
    shoot("ngreply_cleared", 8'h12, 0, 1'b0, 8'h00);

    // Asynchronous reset during LOOKUP
    place(8'h34);
    place(8'h35);
    shoot("pre_rst34", 8'h34, 0, 1'b0, 8'h00);
    shot_valid = 1'b1;
    shot_addr  = 8'h35;
    step();
    shot_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst/valid", msg_valid, 0);
    chk("arst/code", msg_out, 0);
    chk("arst/hits", hits_taken, 0);
    chk("arst/ready", shot_ready, 1);
    chk("arst/defeated", defeated, 0);
    @(posedge clk);
    #1;
    chk("arst/no_reply", msg_valid, 0);
    rst = 1'b0;
    model_clear();
    step();
    chk("arst/ready_after", shot_ready, 1);
    shoot("arst_cleared34", 8'h34, 0, 1'b0, 8'h00);

    // Randomized phase
    for (int it = 0; it < 120; it++) begin
      int sel;
      logic [7:0] a;
      if (m_defeated) do_new_game();
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        do_new_game();
      end else if (sel < 7) begin
        a = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
        place(a);
      end else begin
        if (placed_q.size() > 0 && $urandom_range(0, 1) == 1)
          a = placed_q[$urandom_range(0, placed_q.size() - 1)];
        else
          a = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
        shoot("rand", a, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
